// File: rtl/exec_cond_stage_pkg.sv
// Shared types for the execute-stage condition logic: ARM condition codes,
// NZCV bit positions and the M-stage control bundle.
package exec_cond_stage_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE
    } cond_e;

    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

    typedef struct packed {
        logic valid;
        logic pcsrc;
        logic regwrite;
        logic memtoreg;
        logic memwrite;
    } m_ctrl_t;

endpackage

// File: rtl/exec_cond_stage_cond_check.sv
// cond_check: evaluates an ARM condition field against NZCV flags.
// Purely combinational so any predicated stage can reuse it.
import exec_cond_stage_pkg::*;

module cond_check (
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign n = flags[N_BIT];
    assign z = flags[Z_BIT];
    assign c = flags[C_BIT];
    assign v = flags[V_BIT];

    // Condition table; AL and the 4'hF encoding both always pass.
    always_comb begin
        cond_ex = 1'b1;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            default: cond_ex = 1'b1;
        endcase
    end

endmodule

// File: rtl/exec_cond_stage.sv
// exec_cond_stage: condition evaluation, NZCV flag ownership, squashing of
// failed-condition instructions and the execute-to-memory pipeline register.
// Optional macro EXEC_SQUASH_CNT_EN adds a saturating SquashCnt output that
// counts instructions killed by their condition.
import exec_cond_stage_pkg::*;

module exec_cond_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
`ifdef EXEC_SQUASH_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ValidE,
    input  logic [3:0]        CondE,
    input  logic [1:0]        FlagWriteE,
    input  logic              PCSrcE,
    input  logic              RegWriteE,
    input  logic              MemtoRegE,
    input  logic              MemWriteE,
    input  logic [3:0]        ALUFlags,
    input  logic [DATA_W-1:0] ALUResultE,
    input  logic [DATA_W-1:0] WriteDataE,
    input  logic [REG_AW-1:0] WA3E,
    input  logic              StallM,
    input  logic              FlushM,
    output logic              CondExE,
    output logic              BranchTakenE,
    output logic [3:0]        Flags,
    output logic              ValidM,
    output logic              PCSrcM,
    output logic              RegWriteM,
    output logic              MemtoRegM,
    output logic              MemWriteM,
    output logic [DATA_W-1:0] ALUResultM,
    output logic [DATA_W-1:0] WriteDataM,
    output logic [REG_AW-1:0] WA3M
`ifdef EXEC_SQUASH_CNT_EN
    ,
    output logic [CNT_W-1:0]  SquashCnt
`endif
);

    logic    pass;
    logic    commit;
    m_ctrl_t m_q;

    cond_check u_cond_check (
        .cond    (CondE),
        .flags   (Flags),
        .cond_ex (CondExE)
    );

    assign pass         = ValidE & CondExE;
    assign commit       = pass & ~StallM & ~FlushM;
    assign BranchTakenE = PCSrcE & CondExE & ValidE & ~FlushM;

    // Architectural flags change only when the instruction actually commits,
    // so a stalled instruction keeps seeing the same flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Flags <= 4'b0000;
        end else if (commit) begin
            if (FlagWriteE[1]) begin
                Flags[N_BIT] <= ALUFlags[N_BIT];
                Flags[Z_BIT] <= ALUFlags[Z_BIT];
            end
            if (FlagWriteE[0]) begin
                Flags[C_BIT] <= ALUFlags[C_BIT];
                Flags[V_BIT] <= ALUFlags[V_BIT];
            end
        end
    end

    // M register: flush beats stall beats normal advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q        <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            WA3M       <= '0;
        end else if (FlushM) begin
            m_q        <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            WA3M       <= '0;
        end else if (!StallM) begin
            m_q.valid    <= pass;
            m_q.pcsrc    <= PCSrcE & pass;
            m_q.regwrite <= RegWriteE & pass;
            m_q.memtoreg <= MemtoRegE & pass;
            m_q.memwrite <= MemWriteE & pass;
            ALUResultM   <= ALUResultE;
            WriteDataM   <= WriteDataE;
            WA3M         <= WA3E;
        end
    end

    assign ValidM    = m_q.valid;
    assign PCSrcM    = m_q.pcsrc;
    assign RegWriteM = m_q.regwrite;
    assign MemtoRegM = m_q.memtoreg;
    assign MemWriteM = m_q.memwrite;

`ifdef EXEC_SQUASH_CNT_EN
    // Saturating count of real instructions dropped by a failed condition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            SquashCnt <= '0;
        end else if (ValidE & ~CondExE & ~StallM & ~FlushM & (SquashCnt != '1)) begin
            SquashCnt <= SquashCnt + 1'b1;
        end
    end
`endif

endmodule

// File: doc/exec_cond_stage.md
Name: exec_cond_stage

Overview:
- Consumer end of the decode-to-execute pipeline register: takes the E-stage control bundle (CondE, FlagWriteE, PCSrcE, RegWriteE, MemtoRegE, MemWriteE) plus ALU results.
- Evaluates the ARM condition field against the architectural NZCV flags register, which it owns, and updates those flags.
- Squashes failed-condition instructions.
- Registers the surviving controls and data into the execute-to-memory pipeline register, with stall and flush.

Parameters:
- DATA_W, 32, width of ALUResult/WriteData paths.
- REG_AW, 4, register-address width for the write-address field.
- CNT_W, 16, width of the squash counter (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- ValidE  in  1  E stage holds a real instruction (0 = bubble).
- CondE  in  4  ARM condition field.
- FlagWriteE  in  2  [1] = write N,Z; [0] = write C,V.
- PCSrcE, RegWriteE, MemtoRegE, MemWriteE  in  1 each  raw decoded controls.
- ALUFlags  in  4  NZCV from ALU, {N,Z,C,V}.
- ALUResultE  in  DATA_W  ALU result.
- WriteDataE  in  DATA_W  store data.
- WA3E  in  REG_AW  destination register.
- StallM  in  1  hold the M register and block the E-stage commit.
- FlushM  in  1  insert a bubble into M and kill the E instruction.
- CondExE  out  1  condition passed (combinational).
- BranchTakenE  out  1  PCSrcE & CondExE & ValidE & ~FlushM (combinational, to fetch).
- Flags  out  4  current architectural NZCV.
- ValidM, PCSrcM, RegWriteM, MemtoRegM, MemWriteM  out  1 each  registered, gated controls.
- ALUResultM, WriteDataM  out  DATA_W  registered data.
- WA3M  out  REG_AW  registered destination.

Behaviour:
- Reset (reset=0, asynchronous): Flags=4'b0000; ValidM, PCSrcM, RegWriteM, MemtoRegM, MemWriteM = 0; ALUResultM, WriteDataM, WA3M = 0. Reset mid-stall or mid-flush overrides everything.
- CondExE is combinational from CondE and Flags, using the ARM table:
  - EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V.
  - HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V).
  - AL (4'hE) = 1; 4'hF = 1.
- Commit condition: commit = ValidE & CondExE & ~StallM & ~FlushM.
- Flags update on the rising edge only when commit:
  - FlagWriteE[1] loads N,Z from ALUFlags[3:2].
  - FlagWriteE[0] loads C,V from ALUFlags[1:0].
  - Bits not selected hold.
- Because flags update only on commit, a stalled instruction re-evaluates against the same flags every cycle.
- Priority of the M register update per cycle: FlushM > StallM > normal.
  - FlushM=1: ValidM and all M controls load 0; data fields are don't-care (implementation loads 0).
  - StallM=1 (no flush): all M outputs hold.
  - Normal: ValidM <= ValidE & CondExE. Each control <= raw control & ValidE & CondExE. Data and WA3M load unconditionally.
- Latency: one cycle from E inputs to M outputs. Flags are visible to the next E instruction in the next cycle; there is no same-cycle forwarding.
- A failed-condition instruction advances as a bubble (ValidM=0, all writes 0) and writes no flags.
- Bubble input (ValidE=0): same as a failed condition; CondExE is still driven but ignored.

Optional Feature:
- Macro: EXEC_SQUASH_CNT_EN.
- When defined:
  - Adds output SquashCnt (CNT_W bits), reset to 0 by reset.
  - Increments on each cycle with ValidE & ~CondExE & ~StallM & ~FlushM.
  - Saturates at all-ones; no wrap.
- When undefined: the port and the counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - Condition-code enum (EQ..AL, 4'h0..4'hE).
  - Flag bit-index constants N_BIT=3, Z_BIT=2, C_BIT=1, V_BIT=0.
  - Packed struct for the M-stage control bundle (valid, pcsrc, regwrite, memtoreg, memwrite).
- One natural sub-module: cond_check (combinational CondE + Flags -> CondExE), reused by any later predicated stage.

Test Plan:
- Reset: hold reset=0 with random inputs -> Flags=0000, ValidM=0, all M outputs 0, and no change on clk edges until reset=1.
- Flag set then use: cycle 1 sends SUBS (CondE=E, FlagWriteE=11, ALUFlags=0100) -> Flags=0100 after the edge. Cycle 2 sends BEQ (CondE=0, PCSrcE=1) -> CondExE=1, BranchTakenE=1, PCSrcM=1 next cycle.
- Failed condition: Flags=0000, CondE=0 (EQ), RegWriteE=1, MemWriteE=1, FlagWriteE=11, ALUFlags=1111 -> ValidM=0, RegWriteM=0, MemWriteM=0, Flags stay 0000.
- Partial flag write: Flags=0011, FlagWriteE=10, ALUFlags=1100, CondE=E -> Flags=1111 (C,V held).
- Stall then flush together: with M holding a valid ALUResultM=32'h1234, assert StallM=1 for 2 cycles with a flag-writing instruction in E -> M holds 32'h1234 and Flags unchanged. Then assert StallM=1 and FlushM=1 together -> ValidM=0 (flush wins), Flags unchanged.
- GT/LE boundaries: Flags N=1,V=1,Z=0 with CondE=C (GT) -> CondExE=1. Z=1 -> 0. N=1,V=0 with CondE=D (LE) -> 1. With EXEC_SQUASH_CNT_EN defined, after 3 failed-condition instructions SquashCnt=3; when preloaded near the top it saturates at 16'hFFFF.
